// File: rtl/rip_axi_bram_slave.sv
// AXI4 slave memory model: word-addressed array with byte-lane writes, FIXED/INCR bursts,
// SLVERR for out-of-range beats and unsupported burst types. One transaction at a time.
module rip_axi_bram_slave #(
    parameter int                    ID_WIDTH   = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ID_WIDTH-1:0]     i_s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   i_s_axi_awaddr,
    input  logic [7:0]              i_s_axi_awlen,
    input  logic [1:0]              i_s_axi_awburst,
    input  logic                    i_s_axi_awvalid,
    output logic                    o_s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   i_s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_s_axi_wstrb,
    input  logic                    i_s_axi_wlast,
    input  logic                    i_s_axi_wvalid,
    output logic                    o_s_axi_wready,
    output logic [ID_WIDTH-1:0]     o_s_axi_bid,
    output logic [1:0]              o_s_axi_bresp,
    output logic                    o_s_axi_bvalid,
    input  logic                    i_s_axi_bready,
    input  logic [ID_WIDTH-1:0]     i_s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   i_s_axi_araddr,
    input  logic [7:0]              i_s_axi_arlen,
    input  logic [1:0]              i_s_axi_arburst,
    input  logic                    i_s_axi_arvalid,
    output logic                    o_s_axi_arready,
    output logic [ID_WIDTH-1:0]     o_s_axi_rid,
    output logic [DATA_WIDTH-1:0]   o_s_axi_rdata,
    output logic [1:0]              o_s_axi_rresp,
    output logic                    o_s_axi_rlast,
    output logic                    o_s_axi_rvalid,
    input  logic                    i_s_axi_rready,
    output logic                    o_busy
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RFETCH,
        ST_RDATA
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]   r_id, w_id_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [7:0]            r_len, w_len_nxt;
    logic [1:0]            r_burst, w_burst_nxt;
    logic [7:0]            r_cnt, w_cnt_nxt;
    logic                  r_err, w_err_nxt;
    logic                  r_awready, w_awready_nxt;
    logic                  r_arready, w_arready_nxt;
    logic                  r_wready, w_wready_nxt;
    logic                  r_bvalid, w_bvalid_nxt;
    logic [ID_WIDTH-1:0]   r_bid, w_bid_nxt;
    logic [1:0]            r_bresp, w_bresp_nxt;
    logic                  r_rvalid, w_rvalid_nxt;
    logic [ID_WIDTH-1:0]   r_rid, w_rid_nxt;
    logic [1:0]            r_rresp, w_rresp_nxt;
    logic                  r_rlast, w_rlast_nxt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH:0]   w_off_ext;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [IDXW-1:0]       w_idx;
    logic                  w_in_range, w_burst_ok, w_beat_ok, w_last_beat, w_beat_err;
    logic [ADDR_WIDTH-1:0] w_addr_adv;
    logic                  w_aw_hs, w_ar_hs, w_w_hs, w_b_hs, w_r_hs, w_mem_we;

    // The extra top bit of the subtraction is the borrow, i.e. addr < BASE_ADDR.
    assign w_off_ext   = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    assign w_word      = w_off_ext[ADDR_WIDTH-1:0] >> LSB;
    assign w_idx       = w_word[IDXW-1:0];
    assign w_in_range  = !w_off_ext[ADDR_WIDTH] && (w_word[ADDR_WIDTH-1:IDXW] == '0);
    assign w_burst_ok  = (r_burst == BURST_FIXED) || (r_burst == BURST_INCR);
    assign w_beat_ok   = w_in_range && w_burst_ok;
    assign w_last_beat = (r_cnt == r_len);
    assign w_addr_adv  = (r_burst == BURST_INCR) ? r_addr + ADDR_WIDTH'(BYTES) : r_addr;

    // Write has priority: arready is masked while awvalid is up so both cannot handshake together.
    assign o_s_axi_arready = r_arready && !i_s_axi_awvalid;

    assign w_aw_hs  = (r_state == ST_IDLE) && r_awready && i_s_axi_awvalid;
    assign w_ar_hs  = (r_state == ST_IDLE) && o_s_axi_arready && i_s_axi_arvalid;
    assign w_w_hs   = r_wready && i_s_axi_wvalid;
    assign w_b_hs   = r_bvalid && i_s_axi_bready;
    assign w_r_hs   = r_rvalid && i_s_axi_rready;
    assign w_mem_we = (r_state == ST_WDATA) && w_w_hs && w_beat_ok;

    always_comb begin
        w_state_nxt   = r_state;
        w_id_nxt      = r_id;
        w_addr_nxt    = r_addr;
        w_len_nxt     = r_len;
        w_burst_nxt   = r_burst;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;
        w_awready_nxt = r_awready;
        w_arready_nxt = r_arready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bid_nxt     = r_bid;
        w_bresp_nxt   = r_bresp;
        w_rvalid_nxt  = r_rvalid;
        w_rid_nxt     = r_rid;
        w_rresp_nxt   = r_rresp;
        w_rlast_nxt   = r_rlast;
        w_beat_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_awready_nxt = 1'b1;
                w_arready_nxt = 1'b1;
                if (w_aw_hs) begin
                    w_id_nxt      = i_s_axi_awid;
                    w_addr_nxt    = i_s_axi_awaddr;
                    w_len_nxt     = i_s_axi_awlen;
                    w_burst_nxt   = i_s_axi_awburst;
                    w_cnt_nxt     = '0;
                    w_err_nxt     = 1'b0;
                    w_awready_nxt = 1'b0;
                    w_arready_nxt = 1'b0;
                    w_wready_nxt  = 1'b1;
                    w_state_nxt   = ST_WDATA;
                end else if (w_ar_hs) begin
                    w_id_nxt      = i_s_axi_arid;
                    w_addr_nxt    = i_s_axi_araddr;
                    w_len_nxt     = i_s_axi_arlen;
                    w_burst_nxt   = i_s_axi_arburst;
                    w_cnt_nxt     = '0;
                    w_err_nxt     = 1'b0;
                    w_awready_nxt = 1'b0;
                    w_arready_nxt = 1'b0;
                    w_state_nxt   = ST_RFETCH;
                end
            end
            ST_WDATA: begin
                if (w_w_hs) begin
                    // The beat counter, not wlast, decides where the burst ends.
                    w_beat_err = !w_beat_ok || (i_s_axi_wlast != w_last_beat);
                    w_err_nxt  = r_err || w_beat_err;
                    if (w_last_beat) begin
                        w_wready_nxt = 1'b0;
                        w_bvalid_nxt = 1'b1;
                        w_bid_nxt    = r_id;
                        w_bresp_nxt  = (r_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state_nxt  = ST_WRESP;
                    end else begin
                        w_cnt_nxt  = r_cnt + 8'd1;
                        w_addr_nxt = w_addr_adv;
                    end
                end
            end
            ST_WRESP: begin
                if (w_b_hs) begin
                    w_bvalid_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_RFETCH: begin
                w_rvalid_nxt = 1'b1;
                w_rid_nxt    = r_id;
                w_rresp_nxt  = w_beat_ok ? RESP_OKAY : RESP_SLVERR;
                w_rlast_nxt  = w_last_beat;
                w_state_nxt  = ST_RDATA;
            end
            ST_RDATA: begin
                if (w_r_hs) begin
                    w_rvalid_nxt = 1'b0;
                    if (r_rlast) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt + 8'd1;
                        w_addr_nxt  = w_addr_adv;
                        w_state_nxt = ST_RFETCH;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= '0;
            r_rvalid  <= 1'b0;
            r_rid     <= '0;
            r_rresp   <= '0;
            r_rlast   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_id      <= w_id_nxt;
            r_addr    <= w_addr_nxt;
            r_len     <= w_len_nxt;
            r_burst   <= w_burst_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_awready <= w_awready_nxt;
            r_arready <= w_arready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bid     <= w_bid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rid     <= w_rid_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rlast   <= w_rlast_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (i_s_axi_wstrb[i]) r_mem[w_idx][i*8 +: 8] <= i_s_axi_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)                    r_rdata <= '0;
        else if (r_state == ST_RFETCH) r_rdata <= w_beat_ok ? r_mem[w_idx] : '0;
    end

    assign o_s_axi_awready = r_awready;
    assign o_s_axi_wready  = r_wready;
    assign o_s_axi_bvalid  = r_bvalid;
    assign o_s_axi_bid     = r_bid;
    assign o_s_axi_bresp   = r_bresp;
    assign o_s_axi_rvalid  = r_rvalid;
    assign o_s_axi_rid     = r_rid;
    assign o_s_axi_rresp   = r_rresp;
    assign o_s_axi_rlast   = r_rlast;
    assign o_s_axi_rdata   = r_rdata;
    assign o_busy          = (r_state != ST_IDLE);
endmodule

// File: tb/tb_rip_axi_bram_slave.sv
// Bench for rip_axi_bram_slave: directed and random AXI traffic, array-based memory model,
// expected B/R responses queued at issue time and checked by an independent monitor.
module tb_rip_axi_bram_slave;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk, rstn;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready, busy;
    logic [3:0]  wstrb;

    rip_axi_bram_slave #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rstn(rstn),
        .i_s_axi_awid(awid), .i_s_axi_awaddr(awaddr), .i_s_axi_awlen(awlen), .i_s_axi_awburst(awburst),
        .i_s_axi_awvalid(awvalid), .o_s_axi_awready(awready),
        .i_s_axi_wdata(wdata), .i_s_axi_wstrb(wstrb), .i_s_axi_wlast(wlast), .i_s_axi_wvalid(wvalid),
        .o_s_axi_wready(wready),
        .o_s_axi_bid(bid), .o_s_axi_bresp(bresp), .o_s_axi_bvalid(bvalid), .i_s_axi_bready(bready),
        .i_s_axi_arid(arid), .i_s_axi_araddr(araddr), .i_s_axi_arlen(arlen), .i_s_axi_arburst(arburst),
        .i_s_axi_arvalid(arvalid), .o_s_axi_arready(arready),
        .o_s_axi_rid(rid), .o_s_axi_rdata(rdata), .o_s_axi_rresp(rresp), .o_s_axi_rlast(rlast),
        .o_s_axi_rvalid(rvalid), .i_s_axi_rready(rready),
        .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; logic [31:0] data; logic last; } r_exp_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    logic [31:0] mmem [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    int n_checks = 0, n_fail = 0, r_beats = 0, b_done = 0, ar_bdone = 0, rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // A beat is served only for FIXED/INCR bursts whose word index lies inside the array.
    function automatic bit m_ok(input logic [31:0] a, input logic [1:0] burst);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (burst == 2'b00 || burst == 2'b01) && off >= 0 && (off / 4) < DEPTH;
    endfunction

    task automatic model_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input logic [1:0] burst, input int bad);
        logic [31:0] a;
        bit          err;
        int          idx;
        b_exp_t      e;
        a = addr;
        err = 0;
        for (int b = 0; b <= len; b++) begin
            if (m_ok(a, burst)) begin
                idx = int'((a - BASE) / 4);
                for (int i = 0; i < 4; i++) if (ws[b][i]) mmem[idx][i*8 +: 8] = wd[b][i*8 +: 8];
            end else begin
                err = 1;
            end
            if (b == bad) err = 1;
            if (burst == 2'b01) a = a + 4;
        end
        e.id = id;
        e.resp = err ? 2'b10 : 2'b00;
        bq.push_back(e);
    endtask

    task automatic model_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst);
        logic [31:0] a;
        r_exp_t      e;
        a = addr;
        for (int b = 0; b <= len; b++) begin
            e.id   = id;
            e.last = (b == len);
            if (m_ok(a, burst)) begin
                e.data = mmem[int'((a - BASE) / 4)];
                e.resp = 2'b00;
            end else begin
                e.data = 32'h0;
                e.resp = 2'b10;
            end
            rq.push_back(e);
            if (burst == 2'b01) a = a + 4;
        end
    endtask

    task automatic drive_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input logic [1:0] burst, input int bad);
        int t;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!awready && t < 300);
        if (!awready) timeout_fail("aw_handshake");
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = (b == len) ^ (b == bad);
            t = 0;
            do begin @(negedge clk); t++; end while (!wready && t < 300);
            if (!wready) begin
                timeout_fail("w_handshake");
                break;
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic drive_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input bit wait_all);
        int t, base;
        base = r_beats;
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 300);
        if (!arready) timeout_fail("ar_handshake");
        @(posedge clk);
        ar_bdone = b_done;
        #1;
        arvalid = 1'b0;
        chk("ar_to_rvalid_cycle1", 64'(rvalid), 64'd0);
        @(posedge clk); #1;
        chk("ar_to_rvalid_cycle2", 64'(rvalid), 64'd1);
        if (wait_all) begin
            t = 0;
            while (r_beats < base + len + 1 && t < 3000) begin @(negedge clk); t++; end
            if (r_beats < base + len + 1) timeout_fail("r_burst");
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((rq.size() != 0 || bq.size() != 0 || busy) && t < 5000) begin @(negedge clk); t++; end
        if (rq.size() != 0 || bq.size() != 0 || busy) timeout_fail("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        rready = 1'b0;
        bready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: begin rready = ($urandom_range(0, 2) != 0); bready = ($urandom_range(0, 2) != 0); end
                1: begin rready = 1'b1; bready = 1'b1; end
                default: begin rready = 1'b0; bready = 1'b1; end
            endcase
        end
    end

    // Monitor: outputs must hold while stalled; each handshake pops and checks one expectation.
    initial begin
        bit          r_stall, b_stall;
        logic [38:0] r_saved;
        logic [5:0]  b_saved;
        r_exp_t      re;
        b_exp_t      be;
        r_stall = 0;
        b_stall = 0;
        r_saved = '0;
        b_saved = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                r_stall = 0;
                b_stall = 0;
            end else begin
                if (r_stall && rvalid) chk("r_stable", 64'({rid, rresp, rdata, rlast}), 64'(r_saved));
                r_stall = rvalid && !rready;
                r_saved = {rid, rresp, rdata, rlast};
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        timeout_fail("r_unexpected_beat");
                    end else begin
                        re = rq.pop_front();
                        chk("r_beat", 64'({rid, rresp, rdata, rlast}), 64'({re.id, re.resp, re.data, re.last}));
                    end
                    r_beats++;
                end
                if (b_stall && bvalid) chk("b_stable", 64'({bid, bresp}), 64'(b_saved));
                b_stall = bvalid && !bready;
                b_saved = {bid, bresp};
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        timeout_fail("b_unexpected");
                    end else begin
                        be = bq.pop_front();
                        chk("b_resp", 64'({bid, bresp}), 64'({be.id, be.resp}));
                    end
                    b_done++;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, base, len, bad, k;
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [3:0]  id;
        int bd;
        rstn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({awready, wready, bvalid, arready, rvalid, busy, bid, bresp, rid, rresp, rlast}), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_readies", 64'({awready, arready, busy}), 64'b110);

        // Fill the whole array so every later read has a defined expectation.
        for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        model_write(4'h0, BASE, DEPTH - 1, 2'b01, -1);
        drive_write(4'h0, BASE, DEPTH - 1, 2'b01, -1);
        wait_drain();

        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        model_write(4'h1, 32'h10, 0, 2'b01, -1); drive_write(4'h1, 32'h10, 0, 2'b01, -1); wait_drain();
        model_read(4'h2, 32'h10, 0, 2'b01);      drive_read(4'h2, 32'h10, 0, 2'b01, 1);   wait_drain();

        wd[0] = 32'h0000_1234; ws[0] = 4'b0011;
        model_write(4'h3, 32'h10, 0, 2'b01, -1); drive_write(4'h3, 32'h10, 0, 2'b01, -1); wait_drain();
        model_read(4'h4, 32'h10, 0, 2'b00);      drive_read(4'h4, 32'h10, 0, 2'b00, 1);   wait_drain();

        for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
        model_write(4'h5, 32'h100, 3, 2'b01, -1); drive_write(4'h5, 32'h100, 3, 2'b01, -1); wait_drain();
        model_read(4'h6, 32'h100, 3, 2'b01);      drive_read(4'h6, 32'h100, 3, 2'b01, 1);   wait_drain();

        for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        model_write(4'h7, BASE + DEPTH * 4, 1, 2'b01, -1); drive_write(4'h7, BASE + DEPTH * 4, 1, 2'b01, -1); wait_drain();
        model_read(4'h8, BASE + DEPTH * 4, 0, 2'b01);      drive_read(4'h8, BASE + DEPTH * 4, 0, 2'b01, 1);   wait_drain();
        model_write(4'h9, 32'h20, 3, 2'b10, -1); drive_write(4'h9, 32'h20, 3, 2'b10, -1); wait_drain();
        model_read(4'hA, 32'h20, 3, 2'b10);      drive_read(4'hA, 32'h20, 3, 2'b10, 1);   wait_drain();
        model_read(4'hB, 32'h20, 3, 2'b01);      drive_read(4'hB, 32'h20, 3, 2'b01, 1);   wait_drain();

        // Simultaneous AW/AR with the read stalled on rready for five cycles.
        for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        rdy_mode = 2;
        model_write(4'hC, 32'h40, 1, 2'b01, -1);
        model_read(4'hD, 32'h40, 1, 2'b01);
        bd = b_done;
        fork
            drive_write(4'hC, 32'h40, 1, 2'b01, -1);
            drive_read(4'hD, 32'h40, 1, 2'b01, 0);
        join
        chk("write_before_read", 64'(ar_bdone > bd), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("rvalid_held_under_stall", 64'(rvalid), 64'd1);
        rdy_mode = 1;
        wait_drain();

        // Reset in the middle of a len7 read.
        model_read(4'hE, 32'h0, 7, 2'b01);
        base = r_beats;
        drive_read(4'hE, 32'h0, 7, 2'b01, 0);
        t = 0;
        while (r_beats < base + 2 && t < 200) begin @(negedge clk); #1; t++; end
        if (r_beats < base + 2) timeout_fail("read_before_reset");
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("midburst_reset_valids", 64'({awready, wready, bvalid, arready, rvalid, busy}), 64'd0);
        rq.delete();
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        chk("no_response_after_reset", 64'(rvalid), 64'd0);
        model_read(4'hF, 32'h100, 3, 2'b01); drive_read(4'hF, 32'h100, 3, 2'b01, 1); wait_drain();
        rdy_mode = 0;

        for (int n = 0; n < 60; n++) begin
            id  = 4'($urandom);
            len = $urandom_range(0, 7);
            k   = $urandom_range(0, 9);
            burst = (k < 4) ? 2'b01 : (k < 8) ? 2'b00 : (k == 8) ? 2'b10 : 2'b11;
            k = $urandom_range(0, 7);
            if (k == 0)      addr = BASE + (DEPTH - 2) * 4;
            else if (k == 1) addr = BASE + DEPTH * 4 + $urandom_range(0, 255);
            else             addr = BASE + $urandom_range(0, DEPTH - 1) * 4 + ((k == 2) ? $urandom_range(1, 3) : 0);
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b <= len; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
                bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
                model_write(id, addr, len, burst, bad);
                drive_write(id, addr, len, burst, bad);
            end else begin
                model_read(id, addr, len, burst);
                drive_read(id, addr, len, burst, 1);
            end
            wait_drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
